// File: rtl/smac_layer_ctrl_fsm_pkg.sv
// Shared types and default sizing for the SMAC layer control FSM.
package smac_ctrl_pkg;

    localparam int PW  = 8;          // max weight precision (bits)
    localparam int PA  = 8;          // max activation precision (bits)
    localparam int MNO = 288;        // max output filters per layer
    localparam int MNV = 224 * 224;  // max conv volumes per layer

    typedef enum logic [3:0] {
        IDLE,
        CONFIG,
        LOAD_W,
        COMPUTE,
        UPDATE_IDX,
        QUANT,
        WRITE_BACK,
        VOL_END,
        VOL_CHK,
        DONE
    } state_t;

endpackage

// File: rtl/smac_layer_ctrl_fsm_if.sv
// Status flags in and counter/datapath strobes out of the layer control FSM.
interface smac_layer_ctrl_fsm_if;
    logic start;
    logic abort;
    logic mem_valid;
    logic wb_ready;
    logic cnt_sr_w7;
    logic term_ac1;
    logic term_ac2;
    logic bit_m;
    logic last_fil;
    logic update;
    logic done_quant;
    logic relu_done;
    logic op_done;

    logic cnt_load;
    logic cnt_clear_start;
    logic cnt_clear_finish;
    logic cnt_clear_vol;
    logic wei_load;
    logic w_en_w;
    logic w_and_s_ac1;
    logic valid_ac2;
    logic valid_ac3;
    logic act_wb;
    logic cnt_in_vol;
    logic busy;
    logic layer_done;

    modport slave (
        input  start, abort, mem_valid, wb_ready, cnt_sr_w7, term_ac1, term_ac2,
               bit_m, last_fil, update, done_quant, relu_done, op_done,
        output cnt_load, cnt_clear_start, cnt_clear_finish, cnt_clear_vol, wei_load,
               w_en_w, w_and_s_ac1, valid_ac2, valid_ac3, act_wb, cnt_in_vol, busy,
               layer_done
    );

    modport master (
        output start, abort, mem_valid, wb_ready, cnt_sr_w7, term_ac1, term_ac2,
               bit_m, last_fil, update, done_quant, relu_done, op_done,
        input  cnt_load, cnt_clear_start, cnt_clear_finish, cnt_clear_vol, wei_load,
               w_en_w, w_and_s_ac1, valid_ac2, valid_ac3, act_wb, cnt_in_vol, busy,
               layer_done
    );
endinterface

// File: rtl/smac_layer_ctrl_fsm_valid_pipe.sv
// One-cycle registration of the ac2/ac3 valid terms; flush wins over capture,
// and the regs hold while the compute stage is stalled.
module smac_valid_pipe (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic flush,
    input  logic ac2_in,
    input  logic ac3_in,
    output logic ac2_q,
    output logic ac3_q
);
    logic ac2_d, ac3_d;

    // next value: clear on flush, capture when enabled, else hold
    always_comb begin
        ac2_d = ac2_q;
        ac3_d = ac3_q;
        if (flush) begin
            ac2_d = 1'b0;
            ac3_d = 1'b0;
        end else if (en) begin
            ac2_d = ac2_in;
            ac3_d = ac3_in;
        end
    end

    // pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac2_q <= 1'b0;
            ac3_q <= 1'b0;
        end else begin
            ac2_q <= ac2_d;
            ac3_q <= ac3_d;
        end
    end
endmodule

// File: rtl/smac_layer_ctrl_fsm.sv
// Layer-level control FSM for the SMAC engine. Strobes are decoded from the
// registered state and gated by this cycle's handshake inputs.
module smac_layer_ctrl_fsm
    import smac_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    smac_layer_ctrl_fsm_if.slave    bus
);
    state_t state_q, state_d;
    logic   vld_ac2_q, vld_ac3_q;
    logic   pipe_en, pipe_flush;

    // capture valid terms only on productive compute cycles; any move out of
    // COMPUTE (including abort) empties the pipe
    assign pipe_en    = (state_q == COMPUTE) && bus.mem_valid;
    assign pipe_flush = (state_d != COMPUTE);

    smac_valid_pipe u_valid_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (pipe_en),
        .flush  (pipe_flush),
        .ac2_in (bus.term_ac1),
        .ac3_in (bus.term_ac2 & bus.bit_m),
        .ac2_q  (vld_ac2_q),
        .ac3_q  (vld_ac3_q)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign bus.busy = (state_q != IDLE);

    // next-state and strobe decode; abort overrides everything
    always_comb begin
        state_d              = state_q;
        bus.cnt_load         = 1'b0;
        bus.cnt_clear_start  = 1'b0;
        bus.cnt_clear_finish = 1'b0;
        bus.cnt_clear_vol    = 1'b0;
        bus.wei_load         = 1'b0;
        bus.w_en_w           = 1'b0;
        bus.w_and_s_ac1      = 1'b0;
        bus.valid_ac2        = 1'b0;
        bus.valid_ac3        = 1'b0;
        bus.act_wb           = 1'b0;
        bus.cnt_in_vol       = 1'b0;
        bus.layer_done       = 1'b0;
        if (bus.abort) begin
            state_d              = IDLE;
            bus.cnt_clear_start  = 1'b1;
            bus.cnt_clear_finish = 1'b1;
            bus.cnt_clear_vol    = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (bus.start) state_d = CONFIG;
                CONFIG: begin
                    bus.cnt_load         = 1'b1;
                    bus.cnt_clear_start  = 1'b1;
                    bus.cnt_clear_finish = 1'b1;
                    bus.cnt_clear_vol    = 1'b1;
                    state_d              = LOAD_W;
                end
                LOAD_W: if (bus.mem_valid) begin
                    bus.wei_load = 1'b1;
                    if (bus.cnt_sr_w7) state_d = COMPUTE;
                end
                COMPUTE: if (bus.mem_valid) begin
                    bus.w_en_w      = 1'b1;
                    bus.w_and_s_ac1 = 1'b1;
                    bus.valid_ac2   = vld_ac2_q;
                    bus.valid_ac3   = vld_ac3_q;
                    if (vld_ac3_q && bus.last_fil) state_d = QUANT;
                    else if (bus.update)           state_d = UPDATE_IDX;
                end
                UPDATE_IDX: begin
                    bus.cnt_clear_start = 1'b1;
                    state_d             = LOAD_W;
                end
                QUANT: if (bus.done_quant) state_d = WRITE_BACK;
                WRITE_BACK: if (bus.wb_ready) begin
                    bus.act_wb = 1'b1;
                    if (bus.relu_done) state_d = VOL_END;
                end
                VOL_END: begin
                    bus.cnt_in_vol       = 1'b1;
                    bus.cnt_clear_finish = 1'b1;
                    state_d              = VOL_CHK;
                end
                VOL_CHK: begin
                    if (bus.op_done) begin
                        state_d = DONE;
                    end else begin
                        bus.cnt_clear_start = 1'b1;
                        state_d             = LOAD_W;
                    end
                end
                DONE: begin
                    bus.layer_done = 1'b1;
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_smac_layer_ctrl_fsm.sv
// Self-checking bench for smac_layer_ctrl_fsm: expected strobe vectors are
// queued as each cycle's stimulus is applied and compared on the falling edge.
module tb_smac_layer_ctrl_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   vol_cnt = 0;
    int   ld_cnt = 0;
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    smac_layer_ctrl_fsm_if bus ();

    smac_layer_ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // output vector bit positions
    localparam logic [12:0] O_LOAD = 13'h1000, O_CS  = 13'h0800, O_CF  = 13'h0400,
                            O_CV   = 13'h0200, O_WEI = 13'h0100, O_WEN = 13'h0080,
                            O_WAS  = 13'h0040, O_V2  = 13'h0020, O_V3  = 13'h0010,
                            O_WB   = 13'h0008, O_VOL = 13'h0004, O_BSY = 13'h0002,
                            O_LD   = 13'h0001;
    localparam logic [12:0] O_CLR3 = O_CS | O_CF | O_CV;
    localparam logic [12:0] O_CMP  = O_WEN | O_WAS | O_BSY;

    logic [12:0] outs;
    assign outs = {bus.cnt_load, bus.cnt_clear_start, bus.cnt_clear_finish, bus.cnt_clear_vol,
                   bus.wei_load, bus.w_en_w, bus.w_and_s_ac1, bus.valid_ac2, bus.valid_ac3,
                   bus.act_wb, bus.cnt_in_vol, bus.busy, bus.layer_done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock: queue the expectation for the stimulus now on the bus,
    // compare on the falling edge, then step past the rising edge
    task automatic cyc(input string tag, input logic [12:0] exp);
        exp_q.push_back(exp);
        @(negedge clk);
        if (outs[2]) vol_cnt++;
        if (outs[0]) ld_cnt++;
        check(tag, {19'd0, outs}, {19'd0, exp_q.pop_front()});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.start = 0; bus.abort = 0; bus.mem_valid = 0; bus.wb_ready = 0;
        bus.cnt_sr_w7 = 0; bus.term_ac1 = 0; bus.term_ac2 = 0; bus.bit_m = 0;
        bus.last_fil = 0; bus.update = 0; bus.done_quant = 0; bus.relu_done = 0;
        bus.op_done = 0;
    endtask

    // start a layer and walk it through CONFIG and one LOAD_W into COMPUTE
    task automatic start_to_compute(input string tag);
        bus.start = 1; bus.mem_valid = 1;
        cyc({tag, "_idle"}, 13'h0);
        bus.start = 0;
        cyc({tag, "_config"}, O_LOAD | O_CLR3 | O_BSY);
        bus.cnt_sr_w7 = 1;
        cyc({tag, "_loadw"}, O_WEI | O_BSY);
        bus.cnt_sr_w7 = 0;
    endtask

    // one volume from LOAD_W/COMPUTE entry through VOL_CHK
    task automatic volume(input string tag, input logic last_vol, input int wb_stall);
        bus.term_ac2 = 1; bus.bit_m = 1; bus.last_fil = 1;
        cyc({tag, "_cmp_t"}, O_CMP);
        bus.term_ac2 = 0; bus.bit_m = 0;
        cyc({tag, "_cmp_v3"}, O_CMP | O_V3);
        bus.last_fil = 0; bus.done_quant = 1;
        cyc({tag, "_quant"}, O_BSY);
        bus.done_quant = 0; bus.wb_ready = 0;
        for (int i = 0; i < wb_stall; i++) cyc({tag, "_wb_stall"}, O_BSY);
        bus.wb_ready = 1;
        cyc({tag, "_wb"}, O_WB | O_BSY);
        bus.relu_done = 1;
        cyc({tag, "_wb_last"}, O_WB | O_BSY);
        bus.relu_done = 0;
        cyc({tag, "_vol_end"}, O_VOL | O_CF | O_BSY);
        bus.op_done = last_vol;
        cyc({tag, "_vol_chk"}, last_vol ? O_BSY : (O_CS | O_BSY));
        bus.op_done = 0;
    endtask

    initial begin
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {19'd0, outs}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // config, LOAD_W with mem_valid toggling, and start ignored while busy
        start_to_compute("a");
        // now in COMPUTE; term_ac1 -> valid_ac2 one cycle later
        bus.term_ac1 = 1;
        cyc("a_cmp_term1", O_CMP);
        bus.term_ac1 = 0;
        cyc("a_cmp_v2", O_CMP | O_V2);
        bus.term_ac2 = 1; bus.bit_m = 1;
        cyc("a_cmp_term2", O_CMP);
        bus.term_ac2 = 0; bus.bit_m = 0;
        cyc("a_cmp_v3_nolast", O_CMP | O_V3);
        bus.update = 1;
        cyc("a_cmp_update", O_CMP);
        bus.update = 0;
        cyc("a_update_idx", O_CS | O_BSY);
        bus.mem_valid = 1;
        cyc("a_loadw_1", O_WEI | O_BSY);
        bus.mem_valid = 0; bus.start = 1;
        cyc("a_loadw_stall", O_BSY);
        bus.mem_valid = 1; bus.start = 0;
        cyc("a_loadw_1b", O_WEI | O_BSY);
        bus.cnt_sr_w7 = 1;
        cyc("a_loadw_w7", O_WEI | O_BSY);
        bus.cnt_sr_w7 = 0;
        bus.term_ac2 = 1; bus.bit_m = 1; bus.last_fil = 1;
        cyc("a_cmp_t", O_CMP);
        bus.term_ac2 = 0; bus.bit_m = 0;
        cyc("a_cmp_exit", O_CMP | O_V3);
        bus.last_fil = 0;
        cyc("a_quant_wait", O_BSY);
        bus.abort = 1;
        cyc("a_quant_abort", O_CLR3 | O_BSY);
        bus.abort = 0;
        cyc("a_after_abort", 13'h0);

        // start and abort together in IDLE: stay idle
        bus.start = 1; bus.abort = 1;
        cyc("b_start_abort", O_CLR3);
        bus.start = 0; bus.abort = 0;
        cyc("b_still_idle", 13'h0);

        // async reset in the middle of COMPUTE
        start_to_compute("c");
        bus.term_ac1 = 1;
        cyc("c_cmp", O_CMP);
        rst_n = 0;
        #1;
        check("c_async_rst", {19'd0, outs}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        bus.term_ac1 = 0;
        @(posedge clk);
        #1;
        cyc("c_post_rst", 13'h0);

        // full two-volume layer with write-back back-pressure
        vol_cnt = 0; ld_cnt = 0;
        start_to_compute("d");
        volume("d_v0", 1'b0, 3);
        bus.cnt_sr_w7 = 1;
        cyc("d_v1_loadw", O_WEI | O_BSY);
        bus.cnt_sr_w7 = 0;
        volume("d_v1", 1'b1, 0);
        cyc("d_done", O_LD | O_BSY);
        cyc("d_idle", 13'h0);
        check("d_vol_pulses", vol_cnt, 32'd2);
        check("d_layer_done_pulses", ld_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
